cache_read_ctrl: RTL

- Multi-port read controller for the rasterizer fragment/texel cache.
- Arbitrates NUM_PORTS read requesters round-robin and drives the tag-array lookup address.
- Returns a one-cycle grant on hit. On miss, issues a line-fill request to memory, stalls, then replays the lookup.
- Sits between fragment pipeline clients and the cache tag/data arrays plus the memory fill interface.

---
 rtl/cache_read_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/cache_read_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cache_read_pkg.sv
// Shared state encodings and sizing helpers for the cache read controller.
package cache_read_pkg;

  typedef enum logic [1:0] {
    READ_IDLE   = 2'b00,
    READ_HIT    = 2'b01,
    READ_STALL  = 2'b10,
    READ_REPLAY = 2'b11
  } read_state_e;

  function automatic int port_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first requester at or above rr_ptr,
// wrapping around.
module rr_arbiter
  import cache_read_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  localparam int PORT_W    = port_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    rr_ptr,
  output logic [PORT_W-1:0]    sel,
  output logic                 any_req
);

  logic [PORT_W-1:0] idx;

  always_comb begin
    sel     = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = PORT_W'((int'(rr_ptr) + i) % NUM_PORTS);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        sel     = idx;
      end
    end
  end

endmodule

// File: rtl/cache_read_ctrl.sv
// Multi-port cache read controller: round-robin lookup, line fill on miss,
// then replay of the stalled owner's lookup.
module cache_read_ctrl
  import cache_read_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  parameter  int ADDR_W    = 16,
  parameter  int CNT_W     = 16,
  localparam int PORT_W    = port_w(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        rd_en,
  input  logic [NUM_PORTS*ADDR_W-1:0] rd_addr,
  output logic [NUM_PORTS-1:0]        rd_gnt,
  output logic [PORT_W-1:0]           rd_port,
  output logic [ADDR_W-1:0]           lookup_addr,
  input  logic                        hit,
  output logic                        mem_req,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic                        mem_done,
  output logic [1:0]                  read_state,
  output logic [CNT_W-1:0]            miss_cnt
);

  read_state_e state, state_n;

  logic [PORT_W-1:0]    rr_ptr, rr_ptr_n;
  logic [PORT_W-1:0]    sel, port_n;
  logic                 any_req;
  logic [NUM_PORTS-1:0] gnt_n;
  logic                 mreq_n;
  logic [ADDR_W-1:0]    maddr_n;
  logic [CNT_W-1:0]     miss_n, miss_inc;
  logic [ADDR_W-1:0]    addr_a [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_addr
    assign addr_a[g] = rd_addr[g*ADDR_W +: ADDR_W];
  end

  function automatic logic [PORT_W-1:0] next_ptr(
    input logic [PORT_W-1:0] p
  );
    return PORT_W'((int'(p) + 1) % NUM_PORTS);
  endfunction

  function automatic logic [NUM_PORTS-1:0] onehot(
    input logic [PORT_W-1:0] p
  );
    logic [NUM_PORTS-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  rr_arbiter #(
    .NUM_PORTS(NUM_PORTS)
  ) u_arb (
    .req    (rd_en),
    .rr_ptr (rr_ptr),
    .sel    (sel),
    .any_req(any_req)
  );

  assign miss_inc   = (&miss_cnt) ? miss_cnt : miss_cnt + CNT_W'(1);
  assign read_state = state;

  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    gnt_n       = '0;
    port_n      = rd_port;
    mreq_n      = mem_req;
    maddr_n     = mem_addr;
    miss_n      = miss_cnt;
    lookup_addr = addr_a[rr_ptr];
    unique case (state)
      READ_IDLE, READ_HIT: begin
        state_n = READ_IDLE;
        if (any_req) begin
          lookup_addr = addr_a[sel];
          port_n      = sel;
          if (hit) begin
            state_n  = READ_HIT;
            gnt_n    = onehot(sel);
            rr_ptr_n = next_ptr(sel);
          end else begin
            state_n = READ_STALL;
            mreq_n  = 1'b1;
            maddr_n = addr_a[sel];
            miss_n  = miss_inc;
          end
        end
      end
      READ_STALL: begin
        lookup_addr = mem_addr;
        if (mem_done) begin
          mreq_n  = 1'b0;
          state_n = READ_REPLAY;
        end
      end
      READ_REPLAY: begin
        lookup_addr = addr_a[rd_port];
        if (!rd_en[rd_port]) begin
          state_n = READ_IDLE;
        end else if (hit) begin
          state_n  = READ_HIT;
          gnt_n    = onehot(rd_port);
          rr_ptr_n = next_ptr(rd_port);
        end else begin
          // line lost between fill and replay: refetch it
          state_n = READ_STALL;
          mreq_n  = 1'b1;
          maddr_n = addr_a[rd_port];
          miss_n  = miss_inc;
        end
      end
      default: state_n = READ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= READ_IDLE;
      rr_ptr   <= '0;
      rd_gnt   <= '0;
      rd_port  <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      miss_cnt <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      rd_gnt   <= gnt_n;
      rd_port  <= port_n;
      mem_req  <= mreq_n;
      mem_addr <= maddr_n;
      miss_cnt <= miss_n;
    end
  end

endmodule
